// File: rtl/axi_stream_insert_header_if.sv
// Bundle of the three stream-facing buses of axi_stream_insert_header:
// the payload input stream, the header input and the packed output stream.
// The slave modport is the view of the header-insert block itself; the
// master modport is the view of whatever surrounds it.
interface axi_stream_insert_header_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
);
    // payload stream into the block
    logic                       valid_in;
    logic [DATA_WIDTH-1:0]      data_in;
    logic [DATA_BYTE_WIDTH-1:0] keep_in;
    logic                       last_in;
    logic                       ready_in;

    // packed stream out of the block
    logic                       valid_out;
    logic [DATA_WIDTH-1:0]      data_out;
    logic [DATA_BYTE_WIDTH-1:0] keep_out;
    logic                       last_out;
    logic                       ready_out;

    // per-frame header
    logic                       valid_insert;
    logic [DATA_WIDTH-1:0]      data_insert;
    logic [DATA_BYTE_WIDTH-1:0] keep_insert;
    logic [BYTE_CNT_WIDTH-1:0]  byte_insert_cnt;
    logic                       ready_insert;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        output ready_in,
        output valid_out, data_out, keep_out, last_out,
        input  ready_out,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_insert
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        input  ready_in,
        input  valid_out, data_out, keep_out, last_out,
        output ready_out,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_insert
    );
endinterface

// File: rtl/axi_stream_insert_header.sv
// axi_stream_insert_header
// Prepends a 1..N byte header to each AXI-Stream frame and repacks header
// and payload into contiguous, MSB-first output beats. One payload beat is
// turned into one output beat per clock; a frame whose tail does not fit
// in the last beat costs one extra flush beat.
//
// Build option:
//   HDR_CNT_FROM_KEEP_EN  defined   -> header length = popcount(keep_insert)
//                         undefined -> header length = byte_insert_cnt + 1
//
// state  | meaning
// -------+---------------------------------------------------------------
// HDR    | waiting for the next frame's header (ready_insert high)
// STREAM | header latched, payload beats merged with the residual bytes
// FLUSH  | last full beat on the bus, leftover residual still to be sent
// TAIL   | beat carrying last_out on the bus, waiting for it to be taken
module axi_stream_insert_header #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_BYTE_WIDTH = DATA_WIDTH / 8,
    parameter int BYTE_CNT_WIDTH  = $clog2(DATA_BYTE_WIDTH)
) (
    input  logic clk,
    input  logic rst_n,
    axi_stream_insert_header_if.slave bus
);

    localparam int N  = DATA_BYTE_WIDTH;
    // residual byte count runs 0..N, so one bit wider than byte_insert_cnt
    localparam int CW = BYTE_CNT_WIDTH + 1;

    typedef enum logic [1:0] {
        HDR    = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        TAIL   = 2'd3
    } state_t;

    state_t                state;

    // residual bytes carried between beats, kept MSB-aligned with zeros below
    logic [DATA_WIDTH-1:0] res_q;
    logic [CW-1:0]         res_cnt;

    logic                  valid_out_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [N-1:0]          keep_out_q;
    logic                  last_out_q;
    logic                  ready_insert_q;

    logic                  out_free;
    logic                  in_fire;
    logic                  hdr_fire;

    int                    keep_cnt;
    int                    hdr_cnt;
    int                    tot;
    int                    over;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [DATA_WIDTH-1:0] carry;
    logic [DATA_WIDTH-1:0] hdr_res;

    function automatic int popcount(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

    // n most-significant bytes set, the rest clear
    function automatic logic [DATA_WIDTH-1:0] byte_mask(input int n);
        return ~({DATA_WIDTH{1'b1}} >> (8 * n));
    endfunction

    // n most-significant keep bits set
    function automatic logic [N-1:0] keep_mask(input int n);
        return ~({N{1'b1}} >> n);
    endfunction

    // the output register can take a new beat when empty or being drained
    assign out_free = !valid_out_q || bus.ready_out;

    assign bus.ready_in     = (state == STREAM) && out_free;
    assign bus.ready_insert = ready_insert_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;

    assign in_fire  = bus.valid_in && bus.ready_in;
    assign hdr_fire = bus.valid_insert && ready_insert_q;

`ifdef HDR_CNT_FROM_KEEP_EN
    logic unused_byte_insert_cnt;
    assign unused_byte_insert_cnt = ^bus.byte_insert_cnt;
`else
    logic unused_keep_insert;
    assign unused_keep_insert = ^bus.keep_insert;
`endif

    // beat assembly: residual on top, then as much of data_in as fits;
    // the part of data_in that does not fit becomes the next residual
    always_comb begin
        keep_cnt  = popcount(bus.keep_in);
        tot       = int'(res_cnt) + keep_cnt;
        over      = (tot > N) ? (tot - N) : 0;
        beat_data = res_q | (bus.data_in >> (8 * int'(res_cnt)));
        carry     = bus.data_in << (8 * (N - int'(res_cnt)));
`ifdef HDR_CNT_FROM_KEEP_EN
        hdr_cnt   = popcount(bus.keep_insert);
`else
        hdr_cnt   = int'(bus.byte_insert_cnt) + 1;
`endif
        // header bytes arrive in the LSBs; move them to the top of the word
        hdr_res   = bus.data_insert << (8 * (N - hdr_cnt));
    end

    // frame sequencing and the registered output beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= HDR;
            res_q          <= '0;
            res_cnt        <= '0;
            valid_out_q    <= 1'b0;
            data_out_q     <= '0;
            keep_out_q     <= '0;
            last_out_q     <= 1'b0;
            ready_insert_q <= 1'b0;
        end else begin
            case (state)
                HDR: begin
                    if (hdr_fire) begin
                        res_q          <= hdr_res;
                        res_cnt        <= CW'(hdr_cnt);
                        ready_insert_q <= 1'b0;
                        state          <= STREAM;
                    end else begin
                        ready_insert_q <= 1'b1;
                    end
                end

                STREAM: begin
                    if (in_fire) begin
                        valid_out_q <= 1'b1;
                        if (bus.last_in && (tot <= N)) begin
                            // whole tail fits in this beat
                            data_out_q <= beat_data & byte_mask(tot);
                            keep_out_q <= keep_mask(tot);
                            last_out_q <= 1'b1;
                            state      <= TAIL;
                        end else begin
                            data_out_q <= beat_data;
                            keep_out_q <= '1;
                            last_out_q <= 1'b0;
                            if (bus.last_in) begin
                                // tail spills over: keep only real bytes for the flush beat
                                res_q   <= carry & byte_mask(over);
                                res_cnt <= CW'(over);
                                state   <= FLUSH;
                            end else begin
                                res_q <= carry;
                            end
                        end
                    end else if (bus.ready_out) begin
                        valid_out_q <= 1'b0;
                    end
                end

                FLUSH: begin
                    if (bus.ready_out) begin
                        valid_out_q <= 1'b1;
                        data_out_q  <= res_q;
                        keep_out_q  <= keep_mask(int'(res_cnt));
                        last_out_q  <= 1'b1;
                        state       <= TAIL;
                    end
                end

                TAIL: begin
                    if (bus.ready_out) begin
                        // header for the next frame is taken from the following cycle
                        valid_out_q    <= 1'b0;
                        last_out_q     <= 1'b0;
                        ready_insert_q <= 1'b1;
                        state          <= HDR;
                    end
                end

                default: begin
                    state <= HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_stream_insert_header.sv
// Testbench for axi_stream_insert_header (N = 4 bytes per beat).
// A byte-queue model rebuilds each frame's expected output beats from the
// handshakes it observes; a negedge monitor compares every accepted output
// beat against it and checks hold-while-stalled and handshake ordering.
module tb_axi_stream_insert_header;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int BCW = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_stream_insert_header_if #(.DATA_WIDTH(W)) bus ();

    axi_stream_insert_header #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus control
    int h_rate   = 100;
    int p_rate   = 100;
    int rdy_rate = 100;
    bit abort    = 1'b0;
    bit chk_tput = 1'b0;

    // frame table
    logic [W-1:0] f_hdr [64];
    int           f_cnt [64];
    int           f_start [64];
    int           f_nb [64];
    int           f_lk [64];
    logic [W-1:0] pw [1024];
    int           nfr = 0;
    int           npw = 0;

    // model
    logic [7:0]   bq [$];
    logic [W-1:0] exp_d [$];
    logic [N-1:0] exp_k [$];
    logic         exp_l [$];
    logic [W-1:0] obs_d [$];
    logic [N-1:0] obs_k [$];
    logic         obs_l [$];
    bit           in_frame  = 1'b0;
    bit           pay_open  = 1'b0;
    bit           prev_stall = 1'b0;
    bit           prev_fire = 1'b0;
    bit           ob_started = 1'b0;
    logic [W-1:0] prev_d;
    logic [N-1:0] prev_k;
    logic         prev_l;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic void add_frame(input logic [W-1:0] h, input int c, input int lk);
        f_hdr[nfr]   = h;
        f_cnt[nfr]   = c;
        f_lk[nfr]    = lk;
        f_start[nfr] = npw;
        f_nb[nfr]    = 0;
        nfr++;
    endfunction

    function automatic void add_word(input logic [W-1:0] w);
        pw[npw] = w;
        npw++;
        f_nb[nfr-1]++;
    endfunction

    function automatic logic [N-1:0] lkmask(input int lk);
        logic [N-1:0] m;
        m = '1;
        return ~(m >> lk);
    endfunction

    // pop cnt bytes from the byte queue into one expected beat
    task automatic emit(input int cnt, input bit lst);
        logic [W-1:0] d;
        logic [N-1:0] k;
        d = '0;
        k = '0;
        for (int i = 0; i < cnt; i++) begin
            d[W-1-8*i -: 8] = bq.pop_front();
            k[N-1-i] = 1'b1;
        end
        exp_d.push_back(d);
        exp_k.push_back(k);
        exp_l.push_back(lst);
    endtask

    // monitor and model update, away from the active edge
    always @(negedge clk) begin
        int h;
        int kc;
        if (!rst_n) begin
            chk("reset_outputs",
                {24'd0, bus.valid_out, bus.last_out, bus.keep_out, bus.data_out,
                 bus.ready_in, bus.ready_insert}, 64'd0);
            bq.delete();
            exp_d.delete();
            exp_k.delete();
            exp_l.delete();
            in_frame   = 1'b0;
            pay_open   = 1'b0;
            prev_stall = 1'b0;
            prev_fire  = 1'b0;
            ob_started = 1'b0;
        end else begin
            if (prev_stall)
                chk("hold", {27'd0, bus.valid_out, bus.data_out, bus.keep_out, bus.last_out},
                    {27'd0, 1'b1, prev_d, prev_k, prev_l});
            if (bus.ready_insert)
                chk("hdr_mid_frame", {63'd0, in_frame}, 64'd0);
            if (bus.ready_in)
                chk("payload_before_hdr", {63'd0, pay_open}, 64'd1);

            if (bus.valid_insert && bus.ready_insert) begin
`ifdef HDR_CNT_FROM_KEEP_EN
                h = $countones(bus.keep_insert);
`else
                h = int'(bus.byte_insert_cnt) + 1;
`endif
                for (int i = h - 1; i >= 0; i--)
                    bq.push_back(bus.data_insert[8*i +: 8]);
                in_frame = 1'b1;
                pay_open = 1'b1;
            end

            if (bus.valid_in && bus.ready_in) begin
                kc = $countones(bus.keep_in);
                for (int i = N - 1; i >= N - kc; i--)
                    bq.push_back(bus.data_in[8*i +: 8]);
                if (bus.last_in) begin
                    while (bq.size() > N) emit(N, 1'b0);
                    emit(bq.size(), 1'b1);
                    pay_open = 1'b0;
                end else begin
                    while (bq.size() >= N) emit(N, 1'b0);
                end
            end

            if (bus.valid_out && bus.ready_out) begin
                if (exp_d.size() == 0) begin
                    chk("unexpected_beat", {27'd0, bus.data_out, bus.keep_out, bus.last_out}, 64'd0);
                end else begin
                    chk("out_beat", {27'd0, bus.data_out, bus.keep_out, bus.last_out},
                        {27'd0, exp_d.pop_front(), exp_k.pop_front(), exp_l.pop_front()});
                end
                if (chk_tput && ob_started)
                    chk("tput_gap", {63'd0, prev_fire}, 64'd1);
                obs_d.push_back(bus.data_out);
                obs_k.push_back(bus.keep_out);
                obs_l.push_back(bus.last_out);
                ob_started = !bus.last_out;
                if (bus.last_out) in_frame = 1'b0;
            end

            prev_fire  = bus.valid_out && bus.ready_out;
            prev_stall = bus.valid_out && !bus.ready_out;
            prev_d     = bus.data_out;
            prev_k     = bus.keep_out;
            prev_l     = bus.last_out;
        end
    end

    // downstream ready
    initial begin
        bus.ready_out = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.ready_out = (rdy_rate >= 100) ? 1'b1 : ($urandom_range(99) < rdy_rate);
        end
    end

    task automatic hdr_proc(input int a, input int b);
        for (int f = a; f < b && !abort; f++) begin
            bit hs;
            int guard;
            hs = 1'b0;
            guard = 0;
            while ($urandom_range(99) >= h_rate) begin
                bus.valid_insert = 1'b0;
                bus.data_insert  = $urandom;
                @(posedge clk);
                #1;
            end
            bus.valid_insert    = 1'b1;
            bus.data_insert     = f_hdr[f];
            bus.byte_insert_cnt = BCW'(f_cnt[f]);
            bus.keep_insert     = N'((1 << (f_cnt[f] + 1)) - 1);
            while (!hs && !abort) begin
                @(negedge clk);
                hs = bus.ready_insert;
                @(posedge clk);
                #1;
                guard++;
                if (guard > 2000) begin
                    chk("hdr_timeout", 64'd1, 64'd0);
                    abort = 1'b1;
                end
            end
        end
        bus.valid_insert = 1'b0;
    endtask

    task automatic pay_proc(input int a, input int b);
        for (int f = a; f < b && !abort; f++) begin
            for (int j = 0; j < f_nb[f] && !abort; j++) begin
                bit hs;
                bit lst;
                int guard;
                hs = 1'b0;
                guard = 0;
                while ($urandom_range(99) >= p_rate) begin
                    bus.valid_in = 1'b0;
                    bus.data_in  = $urandom;
                    @(posedge clk);
                    #1;
                end
                lst          = (j == f_nb[f] - 1);
                bus.valid_in = 1'b1;
                bus.data_in  = pw[f_start[f] + j];
                bus.last_in  = lst;
                bus.keep_in  = lst ? lkmask(f_lk[f]) : '1;
                while (!hs && !abort) begin
                    @(negedge clk);
                    hs = bus.ready_in;
                    @(posedge clk);
                    #1;
                    guard++;
                    if (guard > 2000) begin
                        chk("pay_timeout", 64'd1, 64'd0);
                        abort = 1'b1;
                    end
                end
            end
        end
        bus.valid_in = 1'b0;
        bus.last_in  = 1'b0;
    endtask

    task automatic run(input int a, input int b);
        fork
            hdr_proc(a, b);
            pay_proc(a, b);
        join
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_d.size() != 0 || in_frame || bus.valid_out) && g < 400) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", {62'd0, exp_d.size() != 0, in_frame}, 64'd0);
    endtask

    task automatic clear_obs();
        obs_d.delete();
        obs_k.delete();
        obs_l.delete();
    endtask

    task automatic chk_obs(input int idx, input logic [W-1:0] d, input logic [N-1:0] k, input logic l);
        if (idx >= obs_d.size())
            chk("lit_missing", {32'd0, idx}, {32'd0, obs_d.size()});
        else
            chk("lit_beat", {27'd0, obs_d[idx], obs_k[idx], obs_l[idx]}, {27'd0, d, k, l});
    endtask

    initial begin
        int a;
        bus.valid_in        = 1'b0;
        bus.data_in         = '0;
        bus.keep_in         = '0;
        bus.last_in         = 1'b0;
        bus.valid_insert    = 1'b0;
        bus.data_insert     = '0;
        bus.keep_insert     = '0;
        bus.byte_insert_cnt = '0;

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: 4-byte header, header goes out alone then payload delayed by one beat
        clear_obs();
        a = nfr;
        add_frame(32'hdeadbeef, 3, 4);
        add_word(32'h12345678);
        add_word(32'h12345679);
        run(a, nfr);
        drain();
        chk("t1_count", {32'd0, obs_d.size()}, 64'd3);
        chk_obs(0, 32'hdeadbeef, 4'b1111, 1'b0);
        chk_obs(1, 32'h12345678, 4'b1111, 1'b0);
        chk_obs(2, 32'h12345679, 4'b1111, 1'b1);

        // 2: 2-byte header, tail fits exactly
        clear_obs();
        a = nfr;
        add_frame(32'hdeadbeef, 1, 2);
        add_word(32'h11223344);
        add_word(32'h55667788);
        run(a, nfr);
        drain();
        chk("t2_count", {32'd0, obs_d.size()}, 64'd2);
        chk_obs(0, 32'hbeef1122, 4'b1111, 1'b0);
        chk_obs(1, 32'h33445566, 4'b1111, 1'b1);

        // 3: tail spills into a flush beat
        clear_obs();
        a = nfr;
        add_frame(32'hdeadbeef, 1, 3);
        add_word(32'h11223344);
        add_word(32'h55667788);
        run(a, nfr);
        drain();
        chk("t3_count", {32'd0, obs_d.size()}, 64'd3);
        chk_obs(0, 32'hbeef1122, 4'b1111, 1'b0);
        chk_obs(1, 32'h33445566, 4'b1111, 1'b0);
        chk_obs(2, 32'h77000000, 4'b1000, 1'b1);

        // 4: random valids and backpressure
        h_rate   = 60;
        p_rate   = 70;
        rdy_rate = 60;
        a = nfr;
        for (int f = 0; f < 40; f++) begin
            int nb;
            add_frame($urandom, $urandom_range(3), $urandom_range(4, 1));
            nb = $urandom_range(5, 1);
            for (int j = 0; j < nb; j++) add_word($urandom);
        end
        run(a, nfr);
        drain();
        h_rate   = 100;
        p_rate   = 100;
        rdy_rate = 100;

        // 5: reset pulse in the middle of a frame, then a clean frame
        a = nfr;
        add_frame(32'hcafef00d, 1, 4);
        for (int j = 0; j < 8; j++) add_word(32'h01020304 + j);
        fork
            run(a, nfr);
            begin
                repeat (4) @(posedge clk);
                #1;
                rst_n = 1'b0;
                abort = 1'b1;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        join
        abort = 1'b0;
        @(posedge clk);
        #1;
        clear_obs();
        a = nfr;
        add_frame(32'hdeadbeef, 1, 2);
        add_word(32'h11223344);
        add_word(32'h55667788);
        run(a, nfr);
        drain();
        chk("t5_count", {32'd0, obs_d.size()}, 64'd2);
        chk_obs(0, 32'hbeef1122, 4'b1111, 1'b0);
        chk_obs(1, 32'h33445566, 4'b1111, 1'b1);

        // 6: everything valid and ready, 4-byte headers, frames back to back
        chk_tput = 1'b1;
        a = nfr;
        for (int f = 0; f < 5; f++) begin
            add_frame(32'ha0b0c0d0 + f, 3, 4);
            for (int j = 0; j < 3; j++) add_word({8'(f), 8'(j), 16'h5aa5});
        end
        run(a, nfr);
        drain();
        chk_tput = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
